// File: rtl/fpu_mult_sequencer_if.sv
// Host/datapath bundle for the floating-point multiplier sequencer.
//
// Handshake: start is a level request that is taken only while the sequencer
// is idle (busy low). Once taken, busy stays high until the host has seen ready
// and answered with ack. ready stays high until ack. ack has no effect while
// ready is low. The datapath inputs (zero_operand, mult_done, round_carry,
// overflow, underflow) are status levels. The sequencer samples each one only
// in the phase that consumes it.
interface fpu_mult_sequencer_if;
  logic       start;
  logic       ack;
  logic       zero_operand;
  logic       mult_done;
  logic       round_carry;
  logic       overflow;
  logic       underflow;
  logic       ld_oper;
  logic       ld_exp;
  logic       sgf_start;
  logic       ld_norm;
  logic       ld_round;
  logic       ld_exc;
  logic       ld_result;
  logic [1:0] sel_result;
  logic       busy;
  logic       ready;
  logic       timeout_err;

  // Sequencer side
  modport slave (
    input  start, ack, zero_operand, mult_done, round_carry, overflow, underflow,
    output ld_oper, ld_exp, sgf_start, ld_norm, ld_round, ld_exc, ld_result,
           sel_result, busy, ready, timeout_err
  );

  // Host / datapath side
  modport master (
    output start, ack, zero_operand, mult_done, round_carry, overflow, underflow,
    input  ld_oper, ld_exp, sgf_start, ld_norm, ld_round, ld_exc, ld_result,
           sel_result, busy, ready, timeout_err
  );
endinterface

// File: rtl/fpu_mult_sequencer.sv
// Moore control FSM for the floating-point multiplier datapath. It steps
// through these phases in order: operand load, exponent add, iterative
// significand multiply, normalize, round, exception check and result select.
// Each phase-register strobe is high for one cycle per visit. The strobes are
// registered copies of "next state == X", so they change only on clock edges.
module fpu_mult_sequencer #(
  parameter int W_EXP        = 8,
  parameter int MULT_TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fpu_mult_sequencer_if.slave  bus,
  output logic [3:0]           dbg_state
);

  localparam int CW = $clog2(MULT_TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = CW'(MULT_TIMEOUT - 1);

  // W_EXP does not change the FSM. It exists so that an instance built for a
  // format the datapath cannot handle is rejected when the design elaborates.
  generate
    if (!((W_EXP == 8) || (W_EXP == 11)) || (MULT_TIMEOUT < 2)) begin : g_param_check
      $error("fpu_mult_sequencer: unsupported W_EXP or MULT_TIMEOUT < 2");
    end
  endgenerate

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_LOAD_OPER = 4'd1,
    S_EXP_ADD   = 4'd2,
    S_SGF_START = 4'd3,
    S_SGF_WAIT  = 4'd4,
    S_NORMALIZE = 4'd5,
    S_ROUND     = 4'd6,
    S_EXC_CHECK = 4'd7,
    S_EXC_EVAL  = 4'd8,
    S_RESULT    = 4'd9,
    S_DONE      = 4'd10
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] wait_cnt;
  logic          renorm_done;
  logic          timeout_hit;

  // mult_done wins over timeout when both happen in the same cycle.
  assign timeout_hit = (wait_cnt == CNT_MAX) && !bus.mult_done;
  assign dbg_state   = state;

  // Next-state decision. The registered outputs below are derived from it.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (bus.start) state_nxt = S_LOAD_OPER;
      S_LOAD_OPER: state_nxt = S_EXP_ADD;
      S_EXP_ADD:   state_nxt = bus.zero_operand ? S_RESULT : S_SGF_START;
      S_SGF_START: state_nxt = S_SGF_WAIT;
      S_SGF_WAIT: begin
        if (bus.mult_done)      state_nxt = S_NORMALIZE;
        else if (timeout_hit)   state_nxt = S_RESULT;
      end
      S_NORMALIZE: state_nxt = S_ROUND;
      // At most one renormalization pass. A second carry is ignored.
      S_ROUND:     state_nxt = (bus.round_carry && !renorm_done) ? S_NORMALIZE : S_EXC_CHECK;
      S_EXC_CHECK: state_nxt = S_EXC_EVAL;
      S_EXC_EVAL:  state_nxt = S_RESULT;
      S_RESULT:    state_nxt = S_DONE;
      S_DONE:      if (bus.ack) state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // State register, registered Moore outputs, wait counter and the result select and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      wait_cnt        <= '0;
      renorm_done     <= 1'b0;
      bus.ld_oper     <= 1'b0;
      bus.ld_exp      <= 1'b0;
      bus.sgf_start   <= 1'b0;
      bus.ld_norm     <= 1'b0;
      bus.ld_round    <= 1'b0;
      bus.ld_exc      <= 1'b0;
      bus.ld_result   <= 1'b0;
      bus.sel_result  <= 2'b00;
      bus.busy        <= 1'b0;
      bus.ready       <= 1'b0;
      bus.timeout_err <= 1'b0;
    end else begin
      state         <= state_nxt;
      bus.ld_oper   <= (state_nxt == S_LOAD_OPER);
      bus.ld_exp    <= (state_nxt == S_EXP_ADD);
      bus.sgf_start <= (state_nxt == S_SGF_START);
      bus.ld_norm   <= (state_nxt == S_NORMALIZE);
      bus.ld_round  <= (state_nxt == S_ROUND);
      bus.ld_exc    <= (state_nxt == S_EXC_CHECK);
      bus.ld_result <= (state_nxt == S_RESULT);
      bus.busy      <= (state_nxt != S_IDLE);
      bus.ready     <= (state_nxt == S_DONE);

      case (state)
        S_IDLE: begin
          if (bus.start) begin
            bus.timeout_err <= 1'b0;
            bus.sel_result  <= 2'b00;
            renorm_done     <= 1'b0;
            wait_cnt        <= '0;
          end
        end
        S_EXP_ADD: begin
          if (bus.zero_operand) bus.sel_result <= 2'b01;
        end
        S_SGF_WAIT: begin
          // The counter saturates and does not wrap.
          if (wait_cnt != CNT_MAX) wait_cnt <= wait_cnt + 1'b1;
          if (timeout_hit) begin
            bus.timeout_err <= 1'b1;
            bus.sel_result  <= 2'b11;
          end
        end
        S_ROUND: begin
          if (bus.round_carry && !renorm_done) renorm_done <= 1'b1;
        end
        S_EXC_EVAL: begin
          if (bus.overflow)       bus.sel_result <= 2'b10;
          else if (bus.underflow) bus.sel_result <= 2'b01;
          else                    bus.sel_result <= 2'b00;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_mult_sequencer.sv
// Testbench for fpu_mult_sequencer. The driver issues requests and pushes the
// response predicted by a reference model. A separate monitor pops and checks
// that prediction each time ready rises.
module tb_fpu_mult_sequencer;

  localparam int T = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] dbg_state;

  // Clock
  always #5 clk = ~clk;

  fpu_mult_sequencer_if bus();

  fpu_mult_sequencer #(.W_EXP(8), .MULT_TIMEOUT(T)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  typedef struct packed {
    logic [7:0] lat;      // cycle of the first ready, counted from the accept edge
    logic [1:0] sel;
    logic       terr;
    logic [2:0] n_sgf;
    logic [2:0] n_norm;
    logic [2:0] n_round;
    logic [2:0] n_exc;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  // Reference model derived from the path descriptions. d is the number of
  // cycles mult_done arrives after the first SGF_WAIT cycle. A d of T or more
  // means mult_done never arrives in time.
  function automatic exp_t model(input bit zero, input int d, input bit c, input bit ov, input bit un);
    exp_t e;
    e = '0;
    if (zero) begin
      e.lat = 8'd4; e.sel = 2'b01;
    end else if (d >= T) begin
      e.lat = 8'(T + 5); e.sel = 2'b11; e.terr = 1'b1; e.n_sgf = 3'd1;
    end else begin
      e.lat     = 8'(10 + d + (c ? 2 : 0));
      e.sel     = ov ? 2'b10 : (un ? 2'b01 : 2'b00);
      e.n_sgf   = 3'd1;
      e.n_norm  = c ? 3'd2 : 3'd1;
      e.n_round = c ? 3'd2 : 3'd1;
      e.n_exc   = 3'd1;
    end
    return e;
  endfunction

  // Monitor. It counts the strobes of each operation and checks the prediction when ready rises.
  int   mk;
  bit   mact = 1'b0;
  bit   rseen = 1'b0;
  int   c_sgf, c_norm, c_round, c_exc, c_res, res_cyc;
  exp_t me;

  always @(negedge clk) begin
    if (!rst_n) begin
      mact  = 1'b0;
      rseen = 1'b0;
    end else begin
      if (bus.ld_oper) begin
        mact = 1'b1; mk = 1;
        c_sgf = 0; c_norm = 0; c_round = 0; c_exc = 0; c_res = 0; res_cyc = 0;
        check("terr_clear_on_accept", bus.timeout_err, 0);
        check("busy_in_load", bus.busy, 1);
      end else if (mact) begin
        mk++;
      end
      if (mact) begin
        c_sgf   += int'(bus.sgf_start);
        c_norm  += int'(bus.ld_norm);
        c_round += int'(bus.ld_round);
        c_exc   += int'(bus.ld_exc);
        c_res   += int'(bus.ld_result);
        if (bus.ld_result) res_cyc = mk;
      end
      if (bus.ready && !rseen) begin
        rseen = 1'b1;
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_ready: got ready with no request outstanding");
        end else begin
          me = exp_q.pop_front();
          check("latency",     mact ? mk : 0, me.lat);
          check("sel_result",  bus.sel_result, me.sel);
          check("timeout_err", bus.timeout_err, me.terr);
          check("n_sgf_start", c_sgf, me.n_sgf);
          check("n_ld_norm",   c_norm, me.n_norm);
          check("n_ld_round",  c_round, me.n_round);
          check("n_ld_exc",    c_exc, me.n_exc);
          check("n_ld_result", c_res, 1);
          check("ld_result_cycle", res_cyc, me.lat - 1);
        end
        mact = 1'b0;
      end else if (!bus.ready) begin
        rseen = 1'b0;
      end
    end
  end

  function automatic logic [11:0] out_vec();
    return {bus.ld_oper, bus.ld_exp, bus.sgf_start, bus.ld_norm, bus.ld_round, bus.ld_exc,
            bus.ld_result, bus.sel_result, bus.busy, bus.ready, bus.timeout_err};
  endfunction

  // Driver. It runs one operation from request to acknowledge.
  task automatic run_txn(input bit zero, input int d, input bit c, input bit ov, input bit un,
                         input int ack_dly);
    exp_t e;
    int   k;
    e = model(zero, d, c, ov, un);
    @(negedge clk);
    bus.zero_operand = zero;
    bus.round_carry  = c;
    bus.overflow     = ov;
    bus.underflow    = un;
    bus.mult_done    = 1'b0;
    bus.start        = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    k = 1;
    forever begin
      bus.mult_done = (d < T) && (k >= 4 + d);
      if (bus.ready) break;
      if (k >= 300) begin
        checks++; failures++;
        $display("FAIL ready_timeout: no ready after %0d cycles, required %0d", k, e.lat);
        break;
      end
      @(negedge clk);
      k++;
    end
    repeat (ack_dly) begin
      @(negedge clk);
      check("ready_hold", bus.ready, 1);
    end
    bus.ack = 1'b1;
    @(negedge clk);
    bus.ack = 1'b0;
    bus.mult_done = 1'b0;
    check("ready_after_ack", bus.ready, 0);
    check("busy_after_ack", bus.busy, 0);
    check("terr_sticky_idle", bus.timeout_err, e.terr);
  endtask

  // Starts an operation, then asserts reset in cycle 5 while ld_norm is high.
  task automatic mid_reset();
    int k;
    @(negedge clk);
    bus.zero_operand = 1'b0;
    bus.mult_done    = 1'b1;
    bus.start        = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    k = 1;
    while (k < 5) begin
      @(negedge clk);
      k++;
    end
    check("pre_reset_ld_norm", bus.ld_norm, 1);
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", out_vec(), 0);
    check("async_reset_state", dbg_state, 0);
    bus.mult_done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Stimulus sequence
  initial begin
    bus.start = 1'b0; bus.ack = 1'b0; bus.zero_operand = 1'b0; bus.mult_done = 1'b0;
    bus.round_carry = 1'b0; bus.overflow = 1'b0; bus.underflow = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", out_vec(), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_outputs", out_vec(), 0);

    run_txn(0, 0, 0, 0, 0, 1);       // nominal
    run_txn(1, 0, 0, 0, 0, 0);       // zero operand
    run_txn(0, 0, 1, 0, 0, 0);       // carry held: a single renormalization
    run_txn(0, 0, 0, 1, 1, 2);       // overflow has priority
    run_txn(0, 0, 0, 0, 1, 0);       // underflow only
    run_txn(0, 3, 0, 0, 0, 0);       // extra wait cycles
    run_txn(0, T - 1, 0, 0, 0, 0);   // mult_done in the timeout cycle
    run_txn(0, 1000, 0, 0, 0, 1);    // timeout
    run_txn(0, 0, 0, 0, 0, 0);       // timeout_err cleared by the next accept
    mid_reset();
    run_txn(0, 0, 0, 0, 0, 0);       // fresh start after reset

    for (int i = 0; i < 25; i++) begin
      run_txn($urandom_range(0, 5) == 0,
              ($urandom_range(0, 9) == 0) ? 1000 : int'($urandom_range(0, 6)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 3)));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
